// File: rtl/temp_sched_pkg.sv
// temp_sched_pkg: shared widths and scan FSM states for the temperature scan scheduler
package temp_sched_pkg;
  localparam int TEMP_W = 8;
  localparam int COEF_W = 4;
  localparam int SENS_W = 4;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_CAPTURE, S_OUTPUT} state_t;
endpackage

// File: rtl/temp_scan_scheduler_tick.sv
// sample_tick_gen: period counter that pulses tick on its last count and holds at zero while disabled
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(SAMPLE_PERIOD);
  localparam logic [W-1:0] LAST = W'(SAMPLE_PERIOD - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || !enable || cnt == LAST) ? '0 : cnt + W'(1);
  assign tick = enable && cnt == LAST;
endmodule

// File: rtl/temp_scan_scheduler.sv
// temp_scan_scheduler: time-shares one temperature calculator across channels and streams tagged results
module temp_scan_scheduler
  import temp_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SAMPLE_PERIOD = 16,
  parameter int CH_W = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [TEMP_W*NUM_CH-1:0]   base_temps,
  input  logic [COEF_W*NUM_CH-1:0]   coefs,
  input  logic [SENS_W*NUM_CH-1:0]   sensor_values,
  output logic [TEMP_W-1:0]          calc_base,
  output logic [COEF_W-1:0]          calc_coef,
  output logic [SENS_W-1:0]          calc_sensor,
  input  logic [TEMP_W-1:0]          calc_temp,
  output logic [TEMP_W-1:0]          temp_out,
  output logic [CH_W-1:0]            temp_ch,
  output logic                       temp_valid,
  input  logic                       temp_ready,
  output logic                       scan_busy,
  output logic [7:0]                 overrun_cnt
);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  state_t state, state_nx;
  logic [CH_W-1:0] ch;
  logic tick, xfer, last;
  logic [TEMP_W-1:0] base_arr [NUM_CH];
  logic [COEF_W-1:0] coef_arr [NUM_CH];
  logic [SENS_W-1:0] sens_arr [NUM_CH];
  for (genvar g = 0; g < NUM_CH; g++) begin : g_slice
    assign base_arr[g] = base_temps[g*TEMP_W +: TEMP_W];
    assign coef_arr[g] = coefs[g*COEF_W +: COEF_W];
    assign sens_arr[g] = sensor_values[g*SENS_W +: SENS_W];
  end
  sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .tick(tick)
  );
  assign temp_valid = state == S_OUTPUT;
  assign scan_busy = state inside {S_LOAD, S_CAPTURE, S_OUTPUT};
  assign xfer = temp_valid && temp_ready;
  assign last = ch == LAST_CH;
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = enable ? S_WAIT : S_IDLE;
      S_WAIT:    state_nx = !enable ? S_IDLE : tick ? S_LOAD : S_WAIT;
      S_LOAD:    state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_OUTPUT;
      S_OUTPUT:  state_nx = !xfer ? S_OUTPUT : !last ? S_LOAD : enable ? S_WAIT : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      ch <= '0;
      calc_base <= '0;
      calc_coef <= '0;
      calc_sensor <= '0;
      temp_out <= '0;
      temp_ch <= '0;
      overrun_cnt <= '0;
    end else begin
      if (state == S_LOAD) begin
        calc_base <= base_arr[ch];
        calc_coef <= coef_arr[ch];
        calc_sensor <= sens_arr[ch];
      end
      if (state == S_CAPTURE) begin
        temp_out <= calc_temp;
        temp_ch <= ch;
      end
      if (xfer)
        ch <= last ? '0 : ch + CH_W'(1);
      if (tick && state != S_WAIT && overrun_cnt != 8'hff)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
endmodule
